regfile_wport_arbiter: RTL

- Shares the register file's single write port between the in-order pipeline WB stage and the long-latency unit (LU: mult/div, uncached load).
- Buffers LU results in a small FIFO and drains them into idle WB slots.
- Keeps a pending-destination scoreboard so ID stalls on RAW/WAW against outstanding LU results.
- Forces a pipeline bubble when the LU is starved of write slots.

---
 rtl/regfile_wport_arbiter_pkg.sv | 16 +
 rtl/regfile_wport_arbiter_wport_fifo.sv | 62 ++++++
 rtl/regfile_wport_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared constants and state encodings for the register-file write-port arbiter.
// The optional same-cycle LU bypass is enabled with the REGFILE_ARB_BYPASS_EN macro.
package regfile_wport_arbiter_pkg;

    localparam int REG_DATA_W       = 32;
    localparam int ARB_REG_NUM      = 32;
    localparam int ARB_FIFO_DEPTH   = 2;
    localparam int ARB_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_WAIT   = 2'd1,
        ARB_BUBBLE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/regfile_wport_arbiter_wport_fifo.sv
// Parametric synchronous FIFO buffering LU results until a free write slot.
// The caller guarantees no push when full and no pop when empty.
module wport_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Shares the register-file write port between WB and the long-latency unit, tracks
// pending LU destinations for ID hazards, and requests a bubble when the LU starves.
import regfile_wport_arbiter_pkg::*;

module regfile_wport_arbiter #(
    parameter int FIFO_DEPTH   = ARB_FIFO_DEPTH,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT,
    parameter int REG_NUM      = ARB_REG_NUM
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_we,
    input  logic [$clog2(REG_NUM)-1:0] wb_waddr,
    input  logic [31:0]                wb_wdata,
    input  logic                       lu_valid,
    output logic                       lu_ready,
    input  logic [$clog2(REG_NUM)-1:0] lu_waddr,
    input  logic [31:0]                lu_wdata,
    input  logic                       issue_valid,
    input  logic [$clog2(REG_NUM)-1:0] issue_waddr,
    input  logic                       id_re1,
    input  logic [$clog2(REG_NUM)-1:0] id_raddr1,
    input  logic                       id_re2,
    input  logic [$clog2(REG_NUM)-1:0] id_raddr2,
    input  logic                       id_we,
    input  logic [$clog2(REG_NUM)-1:0] id_waddr,
    output logic                       raw_stall,
    output logic                       stall_req,
    output logic                       rf_we,
    output logic [$clog2(REG_NUM)-1:0] rf_waddr,
    output logic [31:0]                rf_wdata,
    output logic [1:0]                 dbg_state
);

    localparam int AW    = $clog2(REG_NUM);
    localparam int DW    = REG_DATA_W;
    localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;

    logic          wb_busy;
    logic          bypass;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          blocked;
    logic [AW+DW-1:0] fifo_head;
    logic [AW-1:0] head_waddr;
    logic [DW-1:0] head_wdata;

    logic [REG_NUM-1:0] pending_q, pending_d;
    arb_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    assign {head_waddr, head_wdata} = fifo_head;

    wport_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (AW + DW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({lu_waddr, lu_wdata}),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // WB always owns the port when it writes a real register; $0 writes free the slot.
    always_comb begin
        wb_busy  = wb_we && (wb_waddr != '0);
        lu_ready = !rst && !fifo_full;
        bypass   = 1'b0;
`ifdef REGFILE_ARB_BYPASS_EN
        bypass   = lu_ready && fifo_empty && !wb_busy && lu_valid && (lu_waddr != '0);
`endif
        fifo_pop  = !rst && !fifo_empty && !wb_busy;
        fifo_push = lu_valid && lu_ready && (lu_waddr != '0) && !bypass;
        blocked   = !fifo_empty && !fifo_pop;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        if (!rst) begin
            if (wb_busy) begin
                rf_we    = 1'b1;
                rf_waddr = wb_waddr;
                rf_wdata = wb_wdata;
            end else if (!fifo_empty) begin
                rf_we    = 1'b1;
                rf_waddr = head_waddr;
                rf_wdata = head_wdata;
            end else if (bypass) begin
                rf_we    = 1'b1;
                rf_waddr = lu_waddr;
                rf_wdata = lu_wdata;
            end
        end
    end

    // A new issue to a register being retired in the same cycle keeps it pending.
    always_comb begin
        pending_d = pending_q;
        if (fifo_pop) begin
            pending_d[head_waddr] = 1'b0;
        end
        if (bypass) begin
            pending_d[lu_waddr] = 1'b0;
        end
        if (issue_valid) begin
            pending_d[issue_waddr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    assign raw_stall = !rst && ((id_re1 && pending_q[id_raddr1]) ||
                                (id_re2 && pending_q[id_raddr2]) ||
                                (id_we  && pending_q[id_waddr]));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            cnt_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    // The cycle that enters WAIT is the first blocked cycle, so the count starts at 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (blocked) begin
                    state_d = (STARVE_LIMIT <= 1) ? ARB_BUBBLE : ARB_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ARB_WAIT: begin
                if (!blocked) begin
                    state_d = ARB_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(STARVE_LIMIT - 1)) begin
                    state_d = ARB_BUBBLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ARB_BUBBLE: begin
                if (fifo_pop) begin
                    state_d = ARB_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        stall_req = (state_q == ARB_BUBBLE);
        dbg_state = state_q;
    end

endmodule
